// File: rtl/eeprom_93lc46_responder.sv
// Emulates a 93LC46 serial EEPROM (x8) on oversampled SPI pins: READ/WRITE/ERASE/EWEN/EWDS.
// Latency: SCK pin edge to spi_do update is 3 Clk (2-FF sync + registered output).
// Backpressure: none; the master paces bits, and polls Ready/Busy on DO during the write cycle.
module eeprom_93lc46_responder #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int WR_CYCLES = 250000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic spi_cs,
  input  logic spi_sck,
  input  logic spi_di,
  output logic spi_do,
  output logic spi_do_oe,
  output logic busy,
  output logic wr_enabled
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [31:0] BUSY_LAST = 32'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, OPCODE, ADDR, WDATA, RDATA, IGNORE, BUSY
  } state_t;

  // Synchronised pins and edge detectors
  logic [1:0] cs_sync, sck_sync, di_sync;
  logic       sck_q, cs_q;
  logic       cs_now, di_now, sck_rise, cs_fall;

  // FSM and datapath state
  state_t              state, state_n;
  logic [1:0]          opcode, opcode_n;
  logic [ADDR_W-1:0]   addr, addr_n, addr_shift, addr_inc;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                wr_arm, wr_arm_n, er_arm, er_arm_n, wr_en_n;
  logic [31:0]         busy_cnt, busy_cnt_n;
  logic                do_q, do_n, oe_q, oe_n;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign cs_now     = cs_sync[1];
  assign di_now     = di_sync[1];
  // A bit is only taken while CS is high, so a CS fall in the same cycle discards it.
  assign sck_rise   = sck_sync[1] & ~sck_q & cs_now;
  assign cs_fall    = cs_q & ~cs_now;
  assign addr_shift = {addr[ADDR_W-2:0], di_now};
  assign addr_inc   = addr + 1'b1;

  assign spi_do     = do_q;
  assign spi_do_oe  = oe_q;
  assign busy       = (state == BUSY);

  // Two-flop synchronisers plus one extra stage for edge detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cs_sync  <= '0;
      sck_sync <= '0;
      di_sync  <= '0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[0], spi_cs};
      sck_sync <= {sck_sync[0], spi_sck};
      di_sync  <= {di_sync[0], spi_di};
      sck_q    <= sck_sync[1];
      cs_q     <= cs_now;
    end
  end

  // State register and all datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      opcode     <= '0;
      addr       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      wr_arm     <= 1'b0;
      er_arm     <= 1'b0;
      wr_enabled <= 1'b0;
      busy_cnt   <= '0;
      do_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state      <= state_n;
      opcode     <= opcode_n;
      addr       <= addr_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      wr_arm     <= wr_arm_n;
      er_arm     <= er_arm_n;
      wr_enabled <= wr_en_n;
      busy_cnt   <= busy_cnt_n;
      do_q       <= do_n;
      oe_q       <= oe_n;
    end
  end

  // Storage array; a reset restores the erased (all ones) contents
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '1;
      end
    end else if (mem_we) begin
      mem[addr] <= mem_wdata;
    end
  end

  // Next-state, instruction decode, commit and DO/OE generation
  always_comb begin
    state_n    = state;
    opcode_n   = opcode;
    addr_n     = addr;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    wr_arm_n   = wr_arm;
    er_arm_n   = er_arm;
    wr_en_n    = wr_enabled;
    busy_cnt_n = busy_cnt;
    do_n       = do_q;
    oe_n       = oe_q;
    mem_we     = 1'b0;
    mem_wdata  = shreg;

    if (state == BUSY) begin
      // Self-timed cycle runs regardless of CS or SCK
      if (busy_cnt == BUSY_LAST) begin
        state_n    = IDLE;
        busy_cnt_n = '0;
      end else begin
        busy_cnt_n = busy_cnt + 32'd1;
      end
    end else if (!cs_now) begin
      // CS low discards any partial instruction; a CS fall commits an armed write
      state_n   = IDLE;
      wr_arm_n  = 1'b0;
      er_arm_n  = 1'b0;
      bit_cnt_n = '0;
      if (cs_fall && (wr_arm || er_arm) && wr_enabled) begin
        mem_we     = 1'b1;
        mem_wdata  = er_arm ? '1 : shreg;
        state_n    = BUSY;
        busy_cnt_n = '0;
      end
    end else if (sck_rise) begin
      case (state)
        IDLE: begin
          if (di_now) begin
            state_n   = OPCODE;
            bit_cnt_n = '0;
          end
        end
        OPCODE: begin
          opcode_n = {opcode[0], di_now};
          if (bit_cnt == CNT_W'(1)) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        ADDR: begin
          addr_n = addr_shift;
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt_n = '0;
            case (opcode)
              2'b10: begin
                state_n = RDATA;
                shreg_n = mem[addr_shift];
                do_n    = 1'b0;
              end
              2'b01: state_n = WDATA;
              2'b11: begin
                state_n  = IGNORE;
                er_arm_n = 1'b1;
              end
              default: begin
                state_n = IGNORE;
                if (addr_shift[ADDR_W-1 -: 2] == 2'b11) wr_en_n = 1'b1;
                else if (addr_shift[ADDR_W-1 -: 2] == 2'b00) wr_en_n = 1'b0;
              end
            endcase
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        WDATA: begin
          shreg_n = {shreg[DATA_W-2:0], di_now};
          if (bit_cnt == DATA_LAST) begin
            state_n   = IGNORE;
            wr_arm_n  = 1'b1;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        RDATA: begin
          do_n = shreg[DATA_W-1];
          if (bit_cnt == DATA_LAST) begin
            // Sequential read: roll to the next byte, wrapping at the top
            addr_n    = addr_inc;
            shreg_n   = mem[addr_inc];
            bit_cnt_n = '0;
          end else begin
            shreg_n   = {shreg[DATA_W-2:0], 1'b0};
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // DO: read data while shifting, Ready/Busy status while idle or busy, else quiet
    if (!cs_now) begin
      do_n = 1'b0;
      oe_n = 1'b0;
    end else if (state_n == RDATA) begin
      oe_n = 1'b1;
    end else if (state_n == IDLE || state_n == BUSY) begin
      oe_n = 1'b1;
      do_n = (state_n != BUSY);
    end else begin
      oe_n = 1'b0;
      do_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_eeprom_93lc46_responder.sv
// Directed bench for the 93LC46 responder: reset, read, write protect, write/busy, sequential read, abort/erase, reset mid-busy.
// Latency: samples DO at the end of each SCK high phase (5 Clk after the edge).
// Backpressure: polls busy with bounded loops; a timeout counts as a failed check.
module tb_eeprom_93lc46_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_cs = 1'b0;
  logic spi_sck = 1'b0;
  logic spi_di = 1'b0;
  logic spi_do, spi_do_oe, busy, wr_enabled;

  int errors = 0;
  int checks = 0;

  eeprom_93lc46_responder #(
    .ADDR_W(7),
    .DATA_W(8),
    .WR_CYCLES(20)
  ) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .spi_cs(spi_cs),
    .spi_sck(spi_sck),
    .spi_di(spi_di),
    .spi_do(spi_do),
    .spi_do_oe(spi_do_oe),
    .busy(busy),
    .wr_enabled(wr_enabled)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    spi_di  = b;
    spi_sck = 1'b0;
    tick(5);
    spi_sck = 1'b1;
    tick(5);
    s = spi_do;
    spi_sck = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    logic s;
    for (int i = n - 1; i >= 0; i--) clock_bit(v[i], s);
  endtask

  task automatic cs_start;
    spi_sck = 1'b0;
    spi_di  = 1'b0;
    spi_cs  = 1'b1;
    tick(5);
  endtask

  task automatic cs_end(output logic seen);
    seen    = 1'b0;
    spi_sck = 1'b0;
    tick(5);
    spi_cs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (busy) seen = 1'b1;
    end
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic do_read(input logic [6:0] a, input int nb, output logic dmy, output logic [15:0] data);
    logic s;
    cs_start();
    send(32'b110, 3);
    for (int i = 6; i >= 0; i--) clock_bit(a[i], s);
    dmy  = s;
    data = '0;
    for (int j = 0; j < nb * 8; j++) begin
      clock_bit(1'b0, s);
      data = {data[14:0], s};
    end
    spi_sck = 1'b0;
    tick(5);
    spi_cs = 1'b0;
    tick(6);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, output logic seen, output logic ok);
    cs_start();
    send(32'({3'b101, a}), 10);
    send(32'(d), 8);
    cs_end(seen);
    wait_ready(ok);
  endtask

  task automatic do_ewen;
    logic seen;
    cs_start();
    send(32'b1_00_11_00000, 10);
    cs_end(seen);
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (spi_do !== 1'b0) begin errors++; $display("FAIL reset_do: got %b want 0", spi_do); end
    checks++; if (spi_do_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", spi_do_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (wr_enabled !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", wr_enabled); end
    rst_n = 1'b1;
    tick(3);
    cs_start();
    checks++; if (spi_do_oe !== 1'b1) begin errors++; $display("FAIL idle_status_oe: got %b want 1", spi_do_oe); end
    checks++; if (spi_do !== 1'b1) begin errors++; $display("FAIL idle_status_do: got %b want 1", spi_do); end
    spi_cs = 1'b0;
    tick(5);
    checks++; if (spi_do_oe !== 1'b0) begin errors++; $display("FAIL cs_low_oe: got %b want 0", spi_do_oe); end
  endtask

  task automatic test_read_after_reset;
    logic dmy;
    logic [15:0] d;
    do_read(7'h05, 1, dmy, d);
    checks++; if (dmy !== 1'b0) begin errors++; $display("FAIL rd05_dummy: got %b want 0", dmy); end
    checks++; if (d[7:0] !== 8'hFF) begin errors++; $display("FAIL rd05_data: got %h want ff", d[7:0]); end
    checks++; if (busy !== 1'b0 || wr_enabled !== 1'b0) begin errors++; $display("FAIL rd05_flags: got busy=%b wren=%b want 0 0", busy, wr_enabled); end
  endtask

  task automatic test_write_protect;
    logic seen, ok, dmy;
    logic [15:0] d;
    do_write(7'h10, 8'h5A, seen, ok);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wp_busy: got %b want 0", seen); end
    do_read(7'h10, 1, dmy, d);
    checks++; if (d[7:0] !== 8'hFF) begin errors++; $display("FAIL wp_data: got %h want ff", d[7:0]); end
  endtask

  task automatic test_write_busy;
    logic dmy;
    logic [15:0] d;
    int n, cnt;
    do_ewen();
    checks++; if (wr_enabled !== 1'b1) begin errors++; $display("FAIL ewen: got %b want 1", wr_enabled); end
    cs_start();
    send(32'({3'b101, 7'h10}), 10);
    send(32'h5A, 8);
    spi_sck = 1'b0;
    tick(5);
    spi_cs = 1'b0;
    n = 0;
    while (!busy && n < 10) begin tick(1); n++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", busy); end
    cnt = 0;
    spi_cs = 1'b1;
    while (busy && cnt < 100) begin
      cnt++;
      if (cnt == 10) begin
        checks++; if (spi_do_oe !== 1'b1 || spi_do !== 1'b0) begin errors++; $display("FAIL busy_status: got oe=%b do=%b want 1 0", spi_do_oe, spi_do); end
      end
      tick(1);
    end
    checks++; if (cnt !== 20) begin errors++; $display("FAIL busy_len: got %0d want 20", cnt); end
    checks++; if (spi_do !== 1'b1) begin errors++; $display("FAIL ready_status: got %b want 1", spi_do); end
    spi_cs = 1'b0;
    tick(5);
    do_read(7'h10, 1, dmy, d);
    checks++; if (d[7:0] !== 8'h5A) begin errors++; $display("FAIL rd10_data: got %h want 5a", d[7:0]); end
  endtask

  task automatic test_seq_read;
    logic seen, ok, dmy;
    logic [15:0] d;
    do_write(7'h7F, 8'hA5, seen, ok);
    checks++; if (seen !== 1'b1 || ok !== 1'b1) begin errors++; $display("FAIL wr7f: got seen=%b ok=%b want 1 1", seen, ok); end
    do_write(7'h00, 8'h3C, seen, ok);
    checks++; if (seen !== 1'b1 || ok !== 1'b1) begin errors++; $display("FAIL wr00: got seen=%b ok=%b want 1 1", seen, ok); end
    do_read(7'h7F, 2, dmy, d);
    checks++; if (dmy !== 1'b0) begin errors++; $display("FAIL seq_dummy: got %b want 0", dmy); end
    checks++; if (d[15:8] !== 8'hA5) begin errors++; $display("FAIL seq_byte0: got %h want a5", d[15:8]); end
    checks++; if (d[7:0] !== 8'h3C) begin errors++; $display("FAIL seq_byte1_wrap: got %h want 3c", d[7:0]); end
  endtask

  task automatic test_abort_erase;
    logic seen, ok, dmy;
    logic [15:0] d;
    cs_start();
    send(32'({3'b101, 7'h20}), 10);
    send(32'b1010, 4);
    cs_end(seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", seen); end
    do_read(7'h20, 1, dmy, d);
    checks++; if (d[7:0] !== 8'hFF) begin errors++; $display("FAIL abort_data: got %h want ff", d[7:0]); end
    cs_start();
    send(32'({3'b111, 7'h10}), 10);
    cs_end(seen);
    wait_ready(ok);
    checks++; if (seen !== 1'b1 || ok !== 1'b1) begin errors++; $display("FAIL erase_busy: got seen=%b ok=%b want 1 1", seen, ok); end
    do_read(7'h10, 1, dmy, d);
    checks++; if (d[7:0] !== 8'hFF) begin errors++; $display("FAIL erase_data: got %h want ff", d[7:0]); end
  endtask

  task automatic test_reset_mid_busy;
    logic dmy;
    logic [15:0] d;
    int n;
    cs_start();
    send(32'({3'b101, 7'h05}), 10);
    send(32'h00, 8);
    spi_sck = 1'b0;
    tick(5);
    spi_cs = 1'b0;
    n = 0;
    while (!busy && n < 10) begin tick(1); n++; end
    spi_cs = 1'b1;
    tick(5);
    checks++; if (busy !== 1'b1 || spi_do_oe !== 1'b1) begin errors++; $display("FAIL pre_reset: got busy=%b oe=%b want 1 1", busy, spi_do_oe); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (spi_do_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", spi_do_oe); end
    checks++; if (wr_enabled !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", wr_enabled); end
    spi_cs = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    do_read(7'h7F, 1, dmy, d);
    checks++; if (d[7:0] !== 8'hFF) begin errors++; $display("FAIL rst_mem7f: got %h want ff", d[7:0]); end
    do_read(7'h05, 1, dmy, d);
    checks++; if (d[7:0] !== 8'hFF) begin errors++; $display("FAIL rst_mem05: got %h want ff", d[7:0]); end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_protect();
    test_write_busy();
    test_seq_read();
    test_abort_erase();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
